dcache_port_arbiter: RTL and testbench

//  Shares the single dcache lookup port between three requesters:
//   - page-table walker (PTW, from memory1)
//   - fetch1 uncached/miss reads (FE)
//   - load/store path (LSU, from memory0)

---
 rtl/dcache_port_arbiter_pkg.sv | 21 ++
 rtl/dcache_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and widths for the dcache port arbiter between PTW, fetch1 and LSU.
package dcache_port_arbiter_pkg;

   localparam int unsigned ADDR_W    = 30;
   localparam int unsigned FE_ADDR_W = 27;
   localparam int unsigned ASID_W    = 9;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_PTW,
      OWN_FE,
      OWN_LSU
   } arb_owner_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_DRAIN
   } arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache lookup port between PTW, fetch1 and LSU with one
// outstanding transaction, routing each response back to its issuer.
module dcache_port_arbiter
   import dcache_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                 clk_core,
   input  logic                 reset,
   input  logic                 ptw_req,
   input  logic [ADDR_W-1:0]    ptw_addr,
   input  logic                 fe_req,
   input  logic [FE_ADDR_W-1:0] fe_addr,
   input  logic                 lsu_req,
   input  logic                 lsu_trans,
   input  logic [ADDR_W-1:0]    lsu_addr,
   input  logic [ASID_W-1:0]    asid,
   input  logic                 csr_kill,
   output logic                 ptw_gnt,
   output logic                 fe_gnt,
   output logic                 lsu_gnt,
   output logic                 dc_req,
   output logic                 dc_trans,
   output logic [ASID_W-1:0]    dc_asid,
   output logic [ADDR_W-1:0]    dc_addr,
   input  logic                 dc_ready,
   input  logic                 dc_resp_valid,
   output logic                 ptw_rvalid,
   output logic                 fe_rvalid,
   output logic                 lsu_rvalid,
   output logic                 arb_proto_err
);

   arb_state_t       state_q, state_d;
   arb_owner_t       owner_q, owner_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             err_q, err_d;

   arb_owner_t winner;
   logic       lsu_ok;
   logic       starved;
   logic       idle;
   logic       take;
   logic       busy_resp;

   assign lsu_ok  = lsu_req & ~csr_kill;
   assign starved = (starve_q == CNT_W'(STARVE_MAX));
   assign idle    = (state_q == ARB_IDLE);

   // Winner select: PTW > FE > LSU, LSU promoted to the top once starved
   always_comb begin
      winner = OWN_NONE;
      if (starved && lsu_ok) begin
         winner = OWN_LSU;
      end else if (ptw_req) begin
         winner = OWN_PTW;
      end else if (fe_req) begin
         winner = OWN_FE;
      end else if (lsu_ok) begin
         winner = OWN_LSU;
      end
   end

   assign dc_req   = ~reset & idle & (winner != OWN_NONE);
   assign take     = dc_req & dc_ready;
   assign ptw_gnt  = take & (winner == OWN_PTW);
   assign fe_gnt   = take & (winner == OWN_FE);
   assign lsu_gnt  = take & (winner == OWN_LSU);
   assign dc_trans = dc_req & (winner == OWN_LSU) & lsu_trans;
   assign dc_asid  = reset ? '0 : asid;

   always_comb begin
      dc_addr = '0;
      if (!reset) begin
         case (winner)
            OWN_PTW: dc_addr = ptw_addr;
            OWN_FE:  dc_addr = ADDR_W'(fe_addr);
            OWN_LSU: dc_addr = lsu_addr;
            default: dc_addr = '0;
         endcase
      end
   end

   // A killed LSU transaction never reports its response
   assign busy_resp  = ~reset & (state_q == ARB_BUSY) & dc_resp_valid;
   assign ptw_rvalid = busy_resp & (owner_q == OWN_PTW);
   assign fe_rvalid  = busy_resp & (owner_q == OWN_FE);
   assign lsu_rvalid = busy_resp & (owner_q == OWN_LSU) & ~csr_kill;

   assign arb_proto_err = err_q;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      err_d    = err_q;
      case (state_q)
         ARB_IDLE: begin
            if (dc_resp_valid) begin
               err_d = 1'b1;
            end
            if (take) begin
               owner_d = winner;
               state_d = ARB_BUSY;
            end
            if (lsu_gnt || !lsu_req || csr_kill) begin
               starve_d = '0;
            end else if (!starved) begin
               starve_d = starve_q + CNT_W'(1);
            end
         end
         ARB_BUSY: begin
            if (dc_resp_valid) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
            end else if (csr_kill && (owner_q == OWN_LSU)) begin
               state_d = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (dc_resp_valid) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_NONE;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter: grants, routing,
// starvation promotion, kill handling, backpressure and protocol errors.
module tb_dcache_port_arbiter;

   logic        clk_core = 1'b0;
   logic        reset;
   logic        ptw_req, fe_req, lsu_req, lsu_trans, csr_kill;
   logic [29:0] ptw_addr, lsu_addr;
   logic [26:0] fe_addr;
   logic [8:0]  asid;
   logic        dc_ready, dc_resp_valid;
   logic        ptw_gnt, fe_gnt, lsu_gnt, dc_req, dc_trans;
   logic [8:0]  dc_asid;
   logic [29:0] dc_addr;
   logic        ptw_rvalid, fe_rvalid, lsu_rvalid, arb_proto_err;

   int total = 0;
   int bad   = 0;

   dcache_port_arbiter #(.STARVE_MAX(8), .CNT_W(4)) dut (
      .clk_core      (clk_core),
      .reset         (reset),
      .ptw_req       (ptw_req),
      .ptw_addr      (ptw_addr),
      .fe_req        (fe_req),
      .fe_addr       (fe_addr),
      .lsu_req       (lsu_req),
      .lsu_trans     (lsu_trans),
      .lsu_addr      (lsu_addr),
      .asid          (asid),
      .csr_kill      (csr_kill),
      .ptw_gnt       (ptw_gnt),
      .fe_gnt        (fe_gnt),
      .lsu_gnt       (lsu_gnt),
      .dc_req        (dc_req),
      .dc_trans      (dc_trans),
      .dc_asid       (dc_asid),
      .dc_addr       (dc_addr),
      .dc_ready      (dc_ready),
      .dc_resp_valid (dc_resp_valid),
      .ptw_rvalid    (ptw_rvalid),
      .fe_rvalid     (fe_rvalid),
      .lsu_rvalid    (lsu_rvalid),
      .arb_proto_err (arb_proto_err)
   );

   always #5 clk_core = ~clk_core;

   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      ptw_req = 1'b1; fe_req = 1'b0; lsu_req = 1'b0; lsu_trans = 1'b0; csr_kill = 1'b0;
      ptw_addr = 30'h2AAA_5555; fe_addr = 27'h5AB_CDEF; lsu_addr = 30'h0000_2000;
      asid = 9'h155; dc_ready = 1'b1; dc_resp_valid = 1'b0;
      #2;
      chk("rst_dc_req",  32'(dc_req), 0);
      chk("rst_ptw_gnt", 32'(ptw_gnt), 0);
      chk("rst_dc_asid", 32'(dc_asid), 0);
      chk("rst_dc_addr", 32'(dc_addr), 0);
      chk("rst_err",     32'(arb_proto_err), 0);

      // 1: all request, PTW first, FE after PTW's response, then LSU
      tick();
      reset = 1'b0; fe_req = 1'b1; lsu_req = 1'b1;
      #2;
      chk("t1_ptw_gnt",  32'(ptw_gnt), 1);
      chk("t1_fe_gnt0",  32'(fe_gnt), 0);
      chk("t1_lsu_gnt0", 32'(lsu_gnt), 0);
      chk("t1_addr_ptw", 32'(dc_addr), 32'h2AAA_5555);
      chk("t1_trans0",   32'(dc_trans), 0);
      chk("t1_asid",     32'(dc_asid), 32'h155);
      tick();
      ptw_req = 1'b0;
      #2;
      chk("t1_busy_req", 32'(dc_req), 0);
      chk("t1_busy_fe",  32'(fe_gnt), 0);
      tick();
      tick();
      dc_resp_valid = 1'b1;
      #2;
      chk("t1_ptw_rv",   32'(ptw_rvalid), 1);
      chk("t1_fe_rv0",   32'(fe_rvalid), 0);
      chk("t1_lsu_rv0",  32'(lsu_rvalid), 0);
      chk("t1_fe_gnt_r", 32'(fe_gnt), 0);
      tick();
      dc_resp_valid = 1'b0;
      #2;
      chk("t1_fe_gnt",   32'(fe_gnt), 1);
      chk("t1_addr_fe",  32'(dc_addr), 32'h05AB_CDEF);
      tick();
      fe_req = 1'b0;
      tick();
      dc_resp_valid = 1'b1;
      #2;
      chk("t1_fe_rv",    32'(fe_rvalid), 1);
      chk("t1_ptw_rv0",  32'(ptw_rvalid), 0);
      tick();
      dc_resp_valid = 1'b0;
      #2;
      chk("t1_lsu_gnt",  32'(lsu_gnt), 1);
      chk("t1_addr_lsu", 32'(dc_addr), 32'h0000_2000);
      chk("t1_lsu_tr0",  32'(dc_trans), 0);
      tick();
      lsu_req = 1'b0;
      tick();
      dc_resp_valid = 1'b1;
      #2;
      chk("t1_lsu_rv",   32'(lsu_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0;

      // 2+3: PTW wins 8 times, then starved LSU takes the 9th IDLE cycle
      ptw_req = 1'b1; lsu_req = 1'b1; lsu_trans = 1'b1; lsu_addr = 30'h0000_1000; asid = 9'h0A5;
      for (int i = 0; i < 8; i++) begin
         #2;
         chk("t2_ptw_gnt", 32'(ptw_gnt), 1);
         chk("t2_lsu_gnt0", 32'(lsu_gnt), 0);
         tick();
         dc_resp_valid = 1'b1;
         #2;
         chk("t2_ptw_rv", 32'(ptw_rvalid), 1);
         tick();
         dc_resp_valid = 1'b0;
      end
      #2;
      chk("t2_lsu_gnt",  32'(lsu_gnt), 1);
      chk("t2_ptw_gnt0", 32'(ptw_gnt), 0);
      chk("t3_trans",    32'(dc_trans), 1);
      chk("t3_addr",     32'(dc_addr), 32'h0000_1000);
      chk("t3_asid",     32'(dc_asid), 32'h0A5);
      tick();
      lsu_req = 1'b0; ptw_req = 1'b0; lsu_trans = 1'b0;
      tick();
      dc_resp_valid = 1'b1;
      #2;
      chk("t2_lsu_rv",   32'(lsu_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0; ptw_req = 1'b1; lsu_req = 1'b1;
      #2;
      chk("t2_cnt_clr",  32'(ptw_gnt), 1);
      chk("t2_cnt_clr_l", 32'(lsu_gnt), 0);
      tick();
      ptw_req = 1'b0; lsu_req = 1'b0; dc_resp_valid = 1'b1;
      #2;
      chk("t2_ptw_rv2",  32'(ptw_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0;

      // 4: kill while LSU busy, response two cycles later is drained
      lsu_req = 1'b1; lsu_addr = 30'h0000_3000;
      #2;
      chk("t4_lsu_gnt",  32'(lsu_gnt), 1);
      tick();
      lsu_req = 1'b0; csr_kill = 1'b1;
      #2;
      chk("t4_kill_rv",  32'(lsu_rvalid), 0);
      chk("t4_kill_req", 32'(dc_req), 0);
      tick();
      csr_kill = 1'b0;
      #2;
      chk("t4_drain_req", 32'(dc_req), 0);
      tick();
      dc_resp_valid = 1'b1; fe_req = 1'b1; fe_addr = 27'h000_0123;
      #2;
      chk("t4_drain_rv", 32'(lsu_rvalid), 0);
      chk("t4_drain_fe", 32'(fe_gnt), 0);
      tick();
      dc_resp_valid = 1'b0;
      #2;
      chk("t4_next_gnt", 32'(fe_gnt), 1);
      chk("t4_err0",     32'(arb_proto_err), 0);
      tick();
      fe_req = 1'b0; dc_resp_valid = 1'b1;
      #2;
      chk("t4_fe_rv",    32'(fe_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0;

      // kill coinciding with the LSU response: suppressed, straight to IDLE
      lsu_req = 1'b1;
      #2;
      chk("t4b_lsu_gnt", 32'(lsu_gnt), 1);
      tick();
      lsu_req = 1'b0; csr_kill = 1'b1; dc_resp_valid = 1'b1;
      #2;
      chk("t4b_rv0",     32'(lsu_rvalid), 0);
      tick();
      csr_kill = 1'b0; dc_resp_valid = 1'b0; fe_req = 1'b1;
      #2;
      chk("t4b_idle",    32'(fe_gnt), 1);
      tick();
      fe_req = 1'b0; dc_resp_valid = 1'b1;
      #2;
      chk("t4b_fe_rv",   32'(fe_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0;

      // kill masks LSU in IDLE but not PTW
      lsu_req = 1'b1; csr_kill = 1'b1;
      #2;
      chk("t4c_req0",    32'(dc_req), 0);
      chk("t4c_lsu0",    32'(lsu_gnt), 0);
      ptw_req = 1'b1;
      #1;
      chk("t4c_ptw",     32'(ptw_gnt), 1);
      tick();
      ptw_req = 1'b0; lsu_req = 1'b0; csr_kill = 1'b0; dc_resp_valid = 1'b1;
      #2;
      chk("t4c_ptw_rv",  32'(ptw_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0;

      // 5: backpressure holds the request without granting
      dc_ready = 1'b0; fe_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("t5_fe_gnt0", 32'(fe_gnt), 0);
         chk("t5_dc_req",  32'(dc_req), 1);
         tick();
      end
      dc_ready = 1'b1;
      #2;
      chk("t5_fe_gnt",   32'(fe_gnt), 1);
      tick();
      fe_req = 1'b0; dc_resp_valid = 1'b1;
      #2;
      chk("t5_fe_rv",    32'(fe_rvalid), 1);
      tick();
      dc_resp_valid = 1'b0;

      // 6: stray response in IDLE sets the sticky error
      #2;
      chk("t6_err0",     32'(arb_proto_err), 0);
      dc_resp_valid = 1'b1;
      #1;
      chk("t6_ptw_rv0",  32'(ptw_rvalid), 0);
      chk("t6_fe_rv0",   32'(fe_rvalid), 0);
      chk("t6_lsu_rv0",  32'(lsu_rvalid), 0);
      tick();
      dc_resp_valid = 1'b0;
      #2;
      chk("t6_err1",     32'(arb_proto_err), 1);
      tick();
      tick();
      chk("t6_err_hold", 32'(arb_proto_err), 1);
      reset = 1'b1;
      #2;
      chk("t6_err_rst",  32'(arb_proto_err), 0);
      reset = 1'b0;
      tick();

      // reset mid-transaction, then a late response is a protocol error
      ptw_req = 1'b1;
      #2;
      chk("t6b_ptw_gnt", 32'(ptw_gnt), 1);
      tick();
      ptw_req = 1'b0; reset = 1'b1;
      #1;
      chk("t6b_rst_req", 32'(dc_req), 0);
      reset = 1'b0;
      tick();
      dc_resp_valid = 1'b1;
      #2;
      chk("t6b_late_rv", 32'(ptw_rvalid), 0);
      tick();
      dc_resp_valid = 1'b0;
      #2;
      chk("t6b_err",     32'(arb_proto_err), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
